// File: rtl/bus_interface_gen.sv
// 8088-style bus interface: runs T1..T4 (+TW, TH) cycles on an 8-bit multiplexed AD bus, prefetches into a byte queue, serves byte/word data requests.
// Latency: one CPU-clock tick per T-state; a byte cycle takes 4 ticks plus one per TW, and rsp_valid follows the final capture by one CLKx4 cycle.
// Backpressure: READY stretches T3 via TW; prefetch stalls while the queue is full; req_valid waits (held stable) until the req_ready pulse.
// Optional build macro BIU_WAIT_COUNT_EN adds the wait_count output (ticks spent in TW, saturating).
module bus_interface_gen #(
  parameter int          QDEPTH_LOG2  = 2,
  parameter logic [19:0] RESET_VECTOR = 20'hFFFF0
) (
  input  logic                 CLKx4,
  input  logic                 RESET,
  input  logic                 CLK,
  input  logic                 READY,
  input  logic                 HOLD,
  input  logic [7:0]           inAD,
  output logic [7:0]           outAD,
  output logic [7:0]           enAD,
  output logic [11:0]          A,
  output logic                 ALE,
  output logic                 RD_n,
  output logic                 WR_n,
  output logic                 IOM,
  output logic                 DTR,
  output logic                 DEN_n,
  output logic                 HOLDA,
  output logic [7:0]           q_top,
  output logic [19:0]          q_top_addr,
  output logic                 q_empty,
  output logic                 q_full,
  output logic [QDEPTH_LOG2:0] q_count,
  input  logic                 q_advance,
  input  logic                 flush,
  input  logic [19:0]          flush_addr,
  input  logic                 req_valid,
  input  logic                 req_write,
  input  logic                 req_io,
  input  logic                 req_word,
  input  logic [19:0]          req_addr,
  input  logic [15:0]          req_wdata,
  output logic                 req_ready,
  output logic                 rsp_valid,
  output logic [15:0]          rsp_rdata
`ifdef BIU_WAIT_COUNT_EN
  ,
  output logic [15:0]          wait_count
`endif
);

  localparam int QD = 1 << QDEPTH_LOG2;

  typedef enum logic [2:0] {TI, T1, T2, T3, TW, T4, TH} tState_t;

  tState_t tState;
  logic clkReg, tick;
  logic [19:0] fetchPtr;
  logic [7:0]  qData [QD];
  logic [19:0] qAddr [QD];
  logic [QDEPTH_LOG2:0] wrPtr, rdPtr;
  logic epoch, cycEpoch;
  logic cycData, cycWrite, cycHigh;
  logic [19:0] cycAddr;
  logic reqPend, reqWordR, reqWriteR, reqIoR;
  logic [19:0] reqAddrR;
  logic [15:0] reqWdataR;
  logic capture, push, pop, goFetch;
  logic nextData, nextWrite, nextIo;
  logic [19:0] nextAddr;

  assign tick    = CLK & ~clkReg;
  assign capture = tick && (tState == T3 || tState == TW) && READY;
  // A fetch byte only lands if no flush has happened since its T1 (epoch match) and none is happening now.
  assign push    = capture && !cycData && (cycEpoch == epoch) && !flush;
  assign pop     = q_advance && !q_empty && !flush;
  assign goFetch = flush || !q_full;

  assign q_count    = wrPtr - rdPtr;
  assign q_empty    = (wrPtr == rdPtr);
  assign q_full     = (wrPtr[QDEPTH_LOG2-1:0] == rdPtr[QDEPTH_LOG2-1:0]) &&
                      (wrPtr[QDEPTH_LOG2] != rdPtr[QDEPTH_LOG2]);
  assign q_top      = qData[rdPtr[QDEPTH_LOG2-1:0]];
  assign q_top_addr = qAddr[rdPtr[QDEPTH_LOG2-1:0]];

  // Edge detector for the CPU clock sampled in the CLKx4 domain
  always_ff @(posedge CLKx4) begin
    clkReg <= CLK;
  end

  // Attributes of the cycle that would start at the next arbitration: high byte, new request, else fetch
  always_comb begin
    nextData  = reqPend || req_valid;
    nextWrite = 1'b0;
    nextIo    = 1'b0;
    nextAddr  = flush ? flush_addr : fetchPtr;
    if (reqPend) begin
      nextWrite = reqWriteR;
      nextIo    = reqIoR;
      nextAddr  = reqAddrR + 20'd1;
    end else if (req_valid) begin
      nextWrite = req_write;
      nextIo    = req_io;
      nextAddr  = req_addr;
    end
  end

  // Queue storage: written only by an accepted fetch completion
  always_ff @(posedge CLKx4) begin
    if (push) begin
      qData[wrPtr[QDEPTH_LOG2-1:0]] <= inAD;
      qAddr[wrPtr[QDEPTH_LOG2-1:0]] <= cycAddr;
    end
  end

  // Queue pointers, fetch pointer and flush epoch; flush overrides both push and pop
  always_ff @(posedge CLKx4) begin
    if (RESET) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      epoch    <= 1'b0;
      fetchPtr <= RESET_VECTOR;
    end else if (flush) begin
      rdPtr    <= wrPtr;
      epoch    <= ~epoch;
      fetchPtr <= flush_addr;
    end else begin
      if (push) begin
        wrPtr    <= wrPtr + 1'b1;
        fetchPtr <= fetchPtr + 20'd1;
      end
      if (pop) rdPtr <= rdPtr + 1'b1;
    end
  end

  // Bus-cycle sequencer: T-state and strobes change only on ticks; handshake pulses last one CLKx4 cycle
  always_ff @(posedge CLKx4) begin
    if (RESET) begin
      tState    <= TI;
      ALE       <= 1'b0;
      RD_n      <= 1'b1;
      WR_n      <= 1'b1;
      DEN_n     <= 1'b1;
      IOM       <= 1'b0;
      DTR       <= 1'b0;
      HOLDA     <= 1'b0;
      enAD      <= 8'h00;
      outAD     <= 8'h00;
      A         <= 12'h000;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 16'h0000;
      cycData   <= 1'b0;
      cycWrite  <= 1'b0;
      cycHigh   <= 1'b0;
      cycEpoch  <= 1'b0;
      cycAddr   <= 20'h00000;
      reqPend   <= 1'b0;
      reqWordR  <= 1'b0;
      reqWriteR <= 1'b0;
      reqIoR    <= 1'b0;
      reqAddrR  <= 20'h00000;
      reqWdataR <= 16'h0000;
    end else begin
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      if (tick) begin
        case (tState)
          TI, T4: begin
            if (HOLD) begin
              tState <= TH;
              HOLDA  <= 1'b1;
              enAD   <= 8'h00;
              ALE    <= 1'b0;
              RD_n   <= 1'b1;
              WR_n   <= 1'b1;
              DEN_n  <= 1'b1;
            end else if (nextData || goFetch) begin
              tState   <= T1;
              ALE      <= 1'b1;
              enAD     <= 8'hFF;
              outAD    <= nextAddr[7:0];
              A        <= nextAddr[19:8];
              IOM      <= nextIo;
              DTR      <= nextWrite;
              cycAddr  <= nextAddr;
              cycData  <= nextData;
              cycWrite <= nextWrite;
              cycHigh  <= reqPend;
              cycEpoch <= flush ? ~epoch : epoch;
              if (!reqPend && req_valid) begin
                req_ready <= 1'b1;
                reqWordR  <= req_word;
                reqWriteR <= req_write;
                reqIoR    <= req_io;
                reqAddrR  <= req_addr;
                reqWdataR <= req_wdata;
              end
            end else begin
              tState <= TI;
              enAD   <= 8'h00;
            end
          end
          T1: begin
            tState <= T2;
            ALE    <= 1'b0;
            DEN_n  <= 1'b0;
            if (cycWrite) begin
              WR_n  <= 1'b0;
              outAD <= cycHigh ? reqWdataR[15:8] : reqWdataR[7:0];
            end else begin
              RD_n <= 1'b0;
              enAD <= 8'h00;
            end
          end
          T2: tState <= T3;
          T3, TW: begin
            if (READY) begin
              tState <= T4;
              RD_n   <= 1'b1;
              WR_n   <= 1'b1;
              DEN_n  <= 1'b1;
              if (cycData) begin
                if (!cycWrite) begin
                  if (cycHigh) rsp_rdata[15:8] <= inAD;
                  else         rsp_rdata       <= {8'h00, inAD};
                end
                if (cycHigh || !reqWordR) begin
                  rsp_valid <= 1'b1;
                  reqPend   <= 1'b0;
                end else begin
                  reqPend <= 1'b1;
                end
              end
            end else begin
              tState <= TW;
            end
          end
          TH: begin
            if (!HOLD) begin
              tState <= TI;
              HOLDA  <= 1'b0;
            end
          end
          default: tState <= TI;
        endcase
      end
    end
  end

`ifdef BIU_WAIT_COUNT_EN
  // Saturating count of ticks spent in TW
  always_ff @(posedge CLKx4) begin
    if (RESET) wait_count <= 16'h0000;
    else if (tick && tState == TW && wait_count != 16'hFFFF) wait_count <= wait_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_bus_interface_gen.sv
// Self-checking bench for bus_interface_gen: a memory model answers bus reads, a
// monitor logs bus cycles, and a sequential-address model predicts the prefetch queue.
module tb_bus_interface_gen;

  localparam int QL = 2;

  logic CLKx4, RESET, CLK, READY, HOLD;
  logic [7:0] inAD, outAD, enAD;
  logic [11:0] A;
  logic ALE, RD_n, WR_n, IOM, DTR, DEN_n, HOLDA;
  logic [7:0] q_top;
  logic [19:0] q_top_addr;
  logic q_empty, q_full;
  logic [QL:0] q_count;
  logic q_advance, flush;
  logic [19:0] flush_addr;
  logic req_valid, req_write, req_io, req_word;
  logic [19:0] req_addr;
  logic [15:0] req_wdata;
  logic req_ready, rsp_valid;
  logic [15:0] rsp_rdata;
`ifdef BIU_WAIT_COUNT_EN
  logic [15:0] wait_count;
`endif

  bus_interface_gen #(.QDEPTH_LOG2(QL), .RESET_VECTOR(20'hFFFF0)) dut (
    .CLKx4(CLKx4), .RESET(RESET), .CLK(CLK), .READY(READY), .HOLD(HOLD),
    .inAD(inAD), .outAD(outAD), .enAD(enAD), .A(A),
    .ALE(ALE), .RD_n(RD_n), .WR_n(WR_n), .IOM(IOM), .DTR(DTR), .DEN_n(DEN_n), .HOLDA(HOLDA),
    .q_top(q_top), .q_top_addr(q_top_addr), .q_empty(q_empty), .q_full(q_full),
    .q_count(q_count), .q_advance(q_advance), .flush(flush), .flush_addr(flush_addr),
    .req_valid(req_valid), .req_write(req_write), .req_io(req_io), .req_word(req_word),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata)
`ifdef BIU_WAIT_COUNT_EN
    , .wait_count(wait_count)
`endif
  );

  int nVec = 0, nMis = 0;
  int tickNo = 0, seenTick = 0, t1Tick = -100, waitsNext = 0;
  int rdLowCnt = 0, lastRdLow = 0, rspCnt = 0, rdyCnt = 0;
  logic prevAle = 0, prevRd = 1, prevWr = 1;
  logic [19:0] curAddr = 0, expPtr = 20'hFFFF0;
  logic [7:0] seed;
  logic [7:0] memOv [logic [19:0]];
  logic [19:0] aleLog [$];
  logic [29:0] wrLog [$];

  initial begin CLKx4 = 0; forever #5 CLKx4 = ~CLKx4; end
  initial begin CLK = 0; #2; forever #20 CLK = ~CLK; end
  initial forever begin @(posedge CLK); tickNo++; end

  function automatic logic [7:0] rdByte(input logic [19:0] a);
    if (memOv.exists(a)) return memOv[a];
    return a[7:0] ^ a[19:12] ^ seed;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nMis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic waitTicks(input int n);
    repeat (4 * n) @(negedge CLKx4);
  endtask

  // Bus monitor and memory model: logs address phases and write bytes, times RD_n, answers reads
  initial forever begin
    bit ticked;
    @(negedge CLKx4);
    ticked = (tickNo != seenTick);
    seenTick = tickNo;
    if (ALE && !prevAle) begin
      curAddr = {A, outAD};
      aleLog.push_back(curAddr);
      t1Tick = tickNo;
      rdLowCnt = 0;
    end
    prevAle = ALE;
    if (ticked && !RD_n) rdLowCnt++;
    if (RD_n && !prevRd) lastRdLow = rdLowCnt;
    prevRd = RD_n;
    if (!WR_n && prevWr) wrLog.push_back({DTR, IOM, curAddr, outAD});
    prevWr = WR_n;
    if (rsp_valid) rspCnt++;
    if (req_ready) rdyCnt++;
    inAD = rdByte(curAddr);
    READY = !((tickNo + 1 >= t1Tick + 3) && (tickNo + 1 < t1Tick + 3 + waitsNext));
  end

  task automatic popHead(input string tag);
    int g = 0;
    while (q_empty && g < 800) begin @(negedge CLKx4); g++; end
    chk({tag, "_nonEmpty"}, q_empty, 0);
    chk({tag, "_addr"}, q_top_addr, expPtr);
    chk({tag, "_data"}, q_top, rdByte(expPtr));
    q_advance = 1;
    @(negedge CLKx4);
    q_advance = 0;
    expPtr = expPtr + 20'd1;
  endtask

  task automatic doReq(input logic wr, input logic io, input logic word, input logic [19:0] addr,
                       input logic [15:0] wd, output logic [15:0] rd);
    int g;
    @(negedge CLKx4);
    req_valid = 1; req_write = wr; req_io = io; req_word = word; req_addr = addr; req_wdata = wd;
    g = 0;
    do begin @(negedge CLKx4); g++; end while (!req_ready && g < 2000);
    chk("reqReady", req_ready, 1);
    req_valid = 0;
    g = 0;
    do begin @(negedge CLKx4); g++; end while (!rsp_valid && g < 2000);
    chk("rspValid", rsp_valid, 1);
    rd = rsp_rdata;
    @(negedge CLKx4);
  endtask

  initial begin
    logic [15:0] rd;
    logic io;
    logic [19:0] ra;
    int g, nAle;
    seed = 8'($urandom);
    RESET = 1; HOLD = 0; q_advance = 0; flush = 0; flush_addr = 0;
    req_valid = 0; req_write = 0; req_io = 0; req_word = 0; req_addr = 0; req_wdata = 0;
    inAD = 0; READY = 1;

    // Reset values
    waitTicks(3);
    chk("rst_strobes", {ALE, RD_n, WR_n, DEN_n, IOM, DTR, HOLDA, req_ready, rsp_valid, q_empty, q_full},
        11'b01110000010);
    chk("rst_bus", {enAD, outAD, A}, 28'h0);
    chk("rst_qcount", q_count, 0);
    chk("rst_rdata", rsp_rdata, 0);
    RESET = 0;

    // Prefetch from the reset vector until the queue is full, then idle
    waitTicks(24);
    chk("fill_firstT1", aleLog[0], 20'hFFFF0);
    chk("fill_full", q_full, 1);
    chk("fill_count", q_count, 4);
    chk("fill_cycles", aleLog.size(), 4);
    waitTicks(5);
    chk("fill_idle", aleLog.size(), 4);
    for (int i = 0; i < 4; i++) popHead("pop");
    g = 0;
    while (!q_full && g < 2000) begin @(negedge CLKx4); g++; end
    chk("refill_full", q_full, 1);

    // One fetch with two wait states
    aleLog.delete();
    waitsNext = 2;
    popHead("wpop");
    g = 0;
    while (!q_full && g < 2000) begin @(negedge CLKx4); g++; end
    waitTicks(1);
    chk("tw_rdLow", lastRdLow, 4);
    chk("tw_count", q_count, 4);
    chk("tw_addr", aleLog[0], 20'hFFFF8);
`ifdef BIU_WAIT_COUNT_EN
    chk("tw_waitCount", wait_count, 2);
`endif
    waitsNext = 0;
    waitTicks(4);
    chk("tw_once", aleLog.size(), 1);

    // Word read wrapping the 20-bit address space
    memOv[20'hFFFFF] = 8'h34;
    memOv[20'h00000] = 8'h12;
    aleLog.delete();
    rspCnt = 0;
    doReq(0, 0, 1, 20'hFFFFF, 16'h0, rd);
    waitTicks(4);
    chk("wrap_rdata", rd, 16'h1234);
    chk("wrap_rspPulses", rspCnt, 1);
    chk("wrap_cycles", aleLog.size(), 2);
    chk("wrap_a0", aleLog[0], 20'hFFFFF);
    chk("wrap_a1", aleLog[1], 20'h00000);

    // Word write
    io = 1'($urandom_range(0, 1));
    wrLog.delete();
    doReq(1, io, 1, 20'h00400, 16'hBEEF, rd);
    chk("ww_n", wrLog.size(), 2);
    chk("ww_lo", wrLog[0], {1'b1, io, 20'h00400, 8'hEF});
    chk("ww_hi", wrLog[1], {1'b1, io, 20'h00401, 8'hBE});

    // Randomized data requests with random wait states
    for (int i = 0; i < 8; i++) begin
      int kind;
      logic [15:0] rw;
      ra = 20'($urandom);
      rw = 16'($urandom);
      io = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 2);
      waitsNext = $urandom_range(0, 2);
      if (kind == 0) begin
        doReq(0, io, 0, ra, 16'h0, rd);
        chk("rnd_byteRead", rd[7:0], rdByte(ra));
        chk("rnd_rdLow", lastRdLow, waitsNext + 2);
      end else if (kind == 1) begin
        doReq(0, io, 1, ra, 16'h0, rd);
        chk("rnd_wordRead", rd, {rdByte(ra + 20'd1), rdByte(ra)});
      end else begin
        wrLog.delete();
        doReq(1, io, 1, ra, rw, rd);
        chk("rnd_ww_n", wrLog.size(), 2);
        chk("rnd_ww_lo", wrLog[0], {1'b1, io, ra, rw[7:0]});
        chk("rnd_ww_hi", wrLog[1], {1'b1, io, ra + 20'd1, rw[15:8]});
      end
    end
    waitsNext = 0;

    // Flush during a fetch's T3
    aleLog.delete();
    waitsNext = 3;
    popHead("fpop");
    g = 0;
    while (aleLog.size() < 1 && g < 2000) begin @(negedge CLKx4); g++; end
    g = 0;
    while (DEN_n && g < 2000) begin @(negedge CLKx4); g++; end
    waitTicks(1);
    flush = 1; flush_addr = 20'h12345;
    @(negedge CLKx4);
    flush = 0;
    expPtr = 20'h12345;
    chk("flush_count", q_count, 0);
    q_advance = 1;
    @(negedge CLKx4);
    q_advance = 0;
    chk("emptyPop_count", q_count, 0);
    chk("emptyPop_empty", q_empty, 1);
    waitsNext = 0;
    g = 0;
    while (aleLog.size() < 2 && g < 2000) begin @(negedge CLKx4); g++; end
    chk("flush_nextT1", aleLog[1], 20'h12345);
    chk("flush_discard", q_count, 0);
    popHead("fhead");

    // HOLD while a data request is pending
    ra = 20'($urandom);
    rdyCnt = 0;
    HOLD = 1;
    req_valid = 1; req_write = 0; req_io = 0; req_word = 0; req_addr = ra;
    g = 0;
    while (!HOLDA && g < 2000) begin @(negedge CLKx4); g++; end
    chk("hold_holda", HOLDA, 1);
    chk("hold_enAD", enAD, 8'h00);
    chk("hold_noAccept", rdyCnt, 0);
    nAle = aleLog.size();
    waitTicks(6);
    chk("hold_quiet", aleLog.size(), nAle);
    if (!q_empty) popHead("hpop");
    HOLD = 0;
    g = 0;
    while (!req_ready && g < 2000) begin @(negedge CLKx4); g++; end
    chk("hold_accept", req_ready, 1);
    req_valid = 0;
    g = 0;
    while (!rsp_valid && g < 2000) begin @(negedge CLKx4); g++; end
    chk("hold_rsp", rsp_valid, 1);
    chk("hold_rdata", rsp_rdata[7:0], rdByte(ra));
    chk("hold_release", HOLDA, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
